beep_gen: RTL and testbench

Output-side companion to the key debouncer: drives an active-low piezo buzzer pin with a burst of 1–7 timed tone beeps on each request pulse. Typical sources are the single-cycle key-press pulse or any control FSM. It sits at the pin boundary, opposite the key input path. It owns all millisecond-scale timing so callers only issue one-cycle requests.

---
 rtl/beep_pkg.sv | 22 ++
 rtl/beep_tone.sv | 46 ++++
 rtl/beep_gen.sv | 96 +++++++++
 tb/tb_beep_gen.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/beep_pkg.sv
// Shared definitions for the buzzer burst generator.
// Holds the FSM state encoding, the default timing constants at a 25 MHz clock
// and the clock frequency, which the key debouncer also uses.
package beep_pkg;

  localparam int CLK_HZ        = 25_000_000;
  localparam int TONE_HALF_DEF = 6250;       // 2 kHz tone
  localparam int ON_CYC_DEF    = 2_500_000;  // 100 ms beep
  localparam int OFF_CYC_DEF   = 2_500_000;  // 100 ms gap

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } beep_state_e;

  // Counter width for a 0..n-1 counter, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/beep_tone.sv
// Tone divider for the buzzer.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   en         : the coming cycle is a tone (ON) cycle
//   clr        : the coming cycle is the first of a beep; restart in the active phase
//   phase      : registered buzzer level (0 = driven, 1 = silent); idle high
module beep_tone
  import beep_pkg::*;
#(
  parameter int TONE_HALF = TONE_HALF_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic phase
);

  localparam int TW = cnt_w(TONE_HALF);
  localparam logic [TW-1:0] LAST = TW'(TONE_HALF - 1);

  logic [TW-1:0] cnt;

  // en/clr are driven from the FSM's next state, so phase is already the
  // right level for the cycle in which the FSM sits in ON.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (clr) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt   <= '0;
      phase <= 1'b1;
    end
  end

endmodule

// File: rtl/beep_gen.sv
// Piezo buzzer burst generator: one request pulse plays 1..7 timed beeps.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   beep_req   : one-cycle start pulse (ignored while busy)
//   beep_num   : beep count sampled with beep_req, 0 plays one beep
//   beep_stop  : one-cycle abort, wins over beep_req
//   buzzer     : registered, active-low buzzer pin, idle high
//   busy       : registered, high for the whole burst
module beep_gen
  import beep_pkg::*;
#(
  parameter int TONE_HALF = TONE_HALF_DEF,
  parameter int ON_CYC    = ON_CYC_DEF,
  parameter int OFF_CYC   = OFF_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       beep_req,
  input  logic [2:0] beep_num,
  input  logic       beep_stop,
  output logic       buzzer,
  output logic       busy
);

  localparam int DW = cnt_w((ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC);
  localparam logic [DW-1:0] ON_LAST  = DW'(ON_CYC - 1);
  localparam logic [DW-1:0] OFF_LAST = DW'(OFF_CYC - 1);

  beep_state_e   state, state_d;
  logic [DW-1:0] dur, dur_d;
  logic [2:0]    rem, rem_d;
  logic          tone_en, tone_clr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      dur   <= '0;
      rem   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      dur   <= dur_d;
      rem   <= rem_d;
      busy  <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state;
    dur_d   = '0;
    rem_d   = rem;
    unique case (state)
      IDLE: begin
        rem_d = '0;
        if (beep_req) begin
          rem_d   = (beep_num == 3'd0) ? 3'd1 : beep_num;
          state_d = ON;
        end
      end
      ON: begin
        if (dur == ON_LAST) begin
          rem_d   = rem - 3'd1;
          state_d = (rem == 3'd1) ? IDLE : OFF;
        end else begin
          dur_d = dur + 1'b1;
        end
      end
      OFF: begin
        if (dur == OFF_LAST) state_d = ON;
        else                 dur_d   = dur + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including a simultaneous request.
    if (beep_stop) begin
      state_d = IDLE;
      dur_d   = '0;
      rem_d   = '0;
    end
  end

  // Tone restarts in the active phase on every entry to ON.
  assign tone_en  = (state_d == ON);
  assign tone_clr = (state_d == ON) && (state != ON);

  beep_tone #(
    .TONE_HALF(TONE_HALF)
  ) u_tone (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tone_en),
    .clr  (tone_clr),
    .phase(buzzer)
  );

endmodule

// File: tb/tb_beep_gen.sv
// Directed bench for beep_gen with TONE_HALF=2, ON_CYC=8, OFF_CYC=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_beep_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       beep_req = 1'b0;
  logic [2:0] beep_num = 3'd0;
  logic       beep_stop = 1'b0;
  logic       buzzer;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  beep_gen #(
    .TONE_HALF(2),
    .ON_CYC   (8),
    .OFF_CYC  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .beep_req (beep_req),
    .beep_num (beep_num),
    .beep_stop(beep_stop),
    .buzzer   (buzzer),
    .busy     (busy)
  );

  // Expected buzzer level on cycle i (0 = first cycle after the request edge)
  // of a burst lasting len cycles: 8-cycle beeps 0,0,1,1,0,0,1,1 with
  // 4-cycle high gaps, giving a 12-cycle beep period.
  function automatic logic exp_bz(input int i, input int len);
    logic [7:0] pat;
    int pos;
    pat = 8'b1100_1100;
    if (i >= len) return 1'b1;
    pos = i % 12;
    if (pos >= 8) return 1'b1;
    return pat[pos];
  endfunction

  function automatic logic exp_busy(input int i, input int len);
    return (i < len);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (buzzer !== 1'b1) begin
      n_err++;
      $display("FAIL reset_buzzer: got %b want 1", buzzer);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (buzzer !== 1'b1 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL idle_after_reset cyc %0d: got buzzer=%b busy=%b want 1/0", i, buzzer, busy);
      end
    end
  endtask

  task automatic test_burst(input string name, input logic [2:0] num, input int nb);
    int len;
    len = nb * 8 + (nb - 1) * 4;
    beep_num = num;
    beep_req = 1'b1;
    for (int i = 0; i < len + 3; i++) begin
      @(negedge clk);
      beep_req = 1'b0;
      n_cmp++;
      if (buzzer !== exp_bz(i, len)) begin
        n_err++;
        $display("FAIL %s buzzer cyc %0d: got %b want %b", name, i, buzzer, exp_bz(i, len));
      end
      n_cmp++;
      if (busy !== exp_busy(i, len)) begin
        n_err++;
        $display("FAIL %s busy cyc %0d: got %b want %b", name, i, busy, exp_busy(i, len));
      end
    end
  endtask

  task automatic test_ignore_req();
    beep_num = 3'd1;
    beep_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      beep_req = 1'b0;
      n_cmp++;
      if (buzzer !== exp_bz(i, 8) || busy !== exp_busy(i, 8)) begin
        n_err++;
        $display("FAIL ignore_req cyc %0d: got buzzer=%b busy=%b want %b/%b",
                 i, buzzer, busy, exp_bz(i, 8), exp_busy(i, 8));
      end
      if (i == 3) begin
        beep_req = 1'b1;
        beep_num = 3'd3;
      end
    end
  endtask

  task automatic test_stop();
    beep_num = 3'd3;
    beep_req = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      beep_req  = 1'b0;
      beep_stop = 1'b0;
      n_cmp++;
      if (i <= 16) begin
        if (buzzer !== exp_bz(i, 32) || busy !== exp_busy(i, 32)) begin
          n_err++;
          $display("FAIL stop_pre cyc %0d: got buzzer=%b busy=%b want %b/%b",
                   i, buzzer, busy, exp_bz(i, 32), exp_busy(i, 32));
        end
      end else if (buzzer !== 1'b1 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL stop_post cyc %0d: got buzzer=%b busy=%b want 1/0", i, buzzer, busy);
      end
      // Cycle 16 is the 5th cycle of the second beep.
      if (i == 16) beep_stop = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    beep_num = 3'd2;
    beep_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      beep_req = 1'b0;
      rst_n    = 1'b1;
      n_cmp++;
      if (i <= 9) begin
        if (buzzer !== exp_bz(i, 20) || busy !== exp_busy(i, 20)) begin
          n_err++;
          $display("FAIL rst_mid_pre cyc %0d: got buzzer=%b busy=%b want %b/%b",
                   i, buzzer, busy, exp_bz(i, 20), exp_busy(i, 20));
        end
      end else if (buzzer !== 1'b1 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid_post cyc %0d: got buzzer=%b busy=%b want 1/0", i, buzzer, busy);
      end
      // Cycle 9 lies inside the first OFF gap.
      if (i == 9) rst_n = 1'b0;
    end
  endtask

  task automatic test_req_and_stop();
    beep_num  = 3'd3;
    beep_req  = 1'b1;
    beep_stop = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      beep_req  = 1'b0;
      beep_stop = 1'b0;
      n_cmp++;
      if (buzzer !== 1'b1 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL req_and_stop cyc %0d: got buzzer=%b busy=%b want 1/0", i, buzzer, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic eb, ey;
    beep_num = 3'd1;
    beep_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      beep_req = 1'b0;
      if (i < 9) begin
        eb = exp_bz(i, 8);
        ey = exp_busy(i, 8);
      end else begin
        eb = exp_bz(i - 9, 20);
        ey = exp_busy(i - 9, 20);
      end
      n_cmp++;
      if (buzzer !== eb || busy !== ey) begin
        n_err++;
        $display("FAIL back_to_back cyc %0d: got buzzer=%b busy=%b want %b/%b",
                 i, buzzer, busy, eb, ey);
      end
      // Cycle 8 is the first cycle with busy low: request must be taken.
      if (i == 8) begin
        beep_req = 1'b1;
        beep_num = 3'd2;
      end
    end
  endtask

  initial begin
    test_reset();
    test_burst("burst1", 3'd1, 1);
    test_burst("burst3", 3'd3, 3);
    test_burst("burst0", 3'd0, 1);
    test_ignore_req();
    test_stop();
    test_reset_mid();
    test_req_and_stop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
